// File: rtl/ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_stage_pkg
// Shared definitions for the RV32 execute stage.
//   - alu_op_e   : 5-bit ALUControl codes produced by the ALU control decoder.
//   - fwd_sel_e  : operand-select encodings used by the forwarding muxes.
//   - fwd_select : picks the operand source from the MEM / WB hit flags.
// ----------------------------------------------------------------------------
package ex_stage_pkg;

    // ALUControl codes; anything not listed here is treated like OPNULL by the ALU
    typedef enum logic [4:0] {
        OPADD  = 5'b00000,
        OPSUB  = 5'b00001,
        OPAND  = 5'b00010,
        OPOR   = 5'b00011,
        OPSLT  = 5'b00100,
        OPNULL = 5'b11111
    } alu_op_e;

    // Operand source for the forwarding muxes
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // MEM is the younger producer, so a MEM hit must beat a WB hit
    function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// ----------------------------------------------------------------------------
// ex_alu
// Combinational ALU for the execute stage.
// Ports:
//   a, b        in  XLEN  operands
//   ALUControl  in  5     operation (alu_op_e)
//   result      out XLEN  operation result, mod 2^XLEN
//   zero        out 1     result == 0
// ----------------------------------------------------------------------------
module ex_alu
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      ALUControl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // Operation select; OPNULL and unknown codes deliberately produce 0
    always_comb begin
        result = '0;
        case (ALUControl)
            OPADD:   result = a + b;
            OPSUB:   result = a - b;
            OPAND:   result = a & b;
            OPOR:    result = a | b;
            OPSLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage of the 5-stage RV32 pipeline: resolves rs1/rs2 forwarding,
// runs the ALU and registers the result plus pass-through controls into the
// EX/MEM pipeline register.
//
// Configuration macro: EX_FWD_EN
//   defined   -> rs1/rs2 forwarded from MEM (priority) or WB
//   undefined -> register-file data used directly; forwarding ports ignored
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   idex_valid, ex_stall, ex_flush   pipeline control
//   ALUControl, ALUSrc               ALU operation and operand-B select
//   rs1_data, rs2_data, imm          operand sources
//   rs1_addr, rs2_addr, rd_addr      register numbers
//   RegWrite, MemRead, MemWrite, MemToReg  controls for later stages
//   mem_rd, wb_rd, mem_regwrite, wb_regwrite, mem_fwd_data, wb_fwd_data
//                                    forwarding sources
//   exmem_*                          EX/MEM pipeline register outputs
//   ex_illegal_op                    one-cycle pulse for a squashed OPNULL
// ----------------------------------------------------------------------------
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_valid,
    input  logic              ex_stall,
    input  logic              ex_flush,
    input  logic [4:0]        ALUControl,
    input  logic              ALUSrc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              exmem_valid,
    output logic [XLEN-1:0]   exmem_alu_result,
    output logic [XLEN-1:0]   exmem_store_data,
    output logic [REG_AW-1:0] exmem_rd,
    output logic              exmem_RegWrite,
    output logic              exmem_MemRead,
    output logic              exmem_MemWrite,
    output logic              exmem_MemToReg,
    output logic              exmem_zero,
    output logic              ex_illegal_op
);

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            is_null;
    logic            load_valid;

`ifdef EX_FWD_EN
    fwd_sel_e rs1_sel;
    fwd_sel_e rs2_sel;

    // x0 is never a real producer, so a match on register 0 must not forward
    assign rs1_sel = fwd_select(mem_regwrite && (mem_rd == rs1_addr) && (rs1_addr != '0),
                                wb_regwrite  && (wb_rd  == rs1_addr) && (rs1_addr != '0));
    assign rs2_sel = fwd_select(mem_regwrite && (mem_rd == rs2_addr) && (rs2_addr != '0),
                                wb_regwrite  && (wb_rd  == rs2_addr) && (rs2_addr != '0));

    // rs1 operand mux
    always_comb begin
        rs1_fwd = rs1_data;
        case (rs1_sel)
            FWD_MEM: rs1_fwd = mem_fwd_data;
            FWD_WB:  rs1_fwd = wb_fwd_data;
            default: rs1_fwd = rs1_data;
        endcase
    end

    // rs2 operand mux; also the source of store data
    always_comb begin
        rs2_fwd = rs2_data;
        case (rs2_sel)
            FWD_MEM: rs2_fwd = mem_fwd_data;
            FWD_WB:  rs2_fwd = wb_fwd_data;
            default: rs2_fwd = rs2_data;
        endcase
    end
`else
    logic fwd_unused;

    assign rs1_fwd = rs1_data;
    assign rs2_fwd = rs2_data;

    // Forwarding ports stay in the interface but have no effect in this build
    assign fwd_unused = ^{rs1_addr, rs2_addr, mem_rd, wb_rd, mem_regwrite,
                          wb_regwrite, mem_fwd_data, wb_fwd_data};
`endif

    assign op_b = ALUSrc ? imm : rs2_fwd;

    ex_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .a          (rs1_fwd),
        .b          (op_b),
        .ALUControl (ALUControl),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // A valid OPNULL is squashed into a bubble but reported once
    assign is_null    = (ALUControl == OPNULL);
    assign load_valid = idex_valid && !is_null;

    // EX/MEM register: reset > flush > stall > load.
    // Bubbles clear valid, controls and zero; data fields follow the datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem_valid      <= 1'b0;
            exmem_alu_result <= '0;
            exmem_store_data <= '0;
            exmem_rd         <= '0;
            exmem_RegWrite   <= 1'b0;
            exmem_MemRead    <= 1'b0;
            exmem_MemWrite   <= 1'b0;
            exmem_MemToReg   <= 1'b0;
            exmem_zero       <= 1'b0;
            ex_illegal_op    <= 1'b0;
        end else if (ex_flush) begin
            exmem_valid      <= 1'b0;
            exmem_alu_result <= '0;
            exmem_store_data <= '0;
            exmem_rd         <= '0;
            exmem_RegWrite   <= 1'b0;
            exmem_MemRead    <= 1'b0;
            exmem_MemWrite   <= 1'b0;
            exmem_MemToReg   <= 1'b0;
            exmem_zero       <= 1'b0;
            ex_illegal_op    <= 1'b0;
        end else if (ex_stall) begin
            ex_illegal_op    <= 1'b0;
        end else begin
            exmem_valid      <= load_valid;
            exmem_alu_result <= alu_result;
            exmem_store_data <= rs2_fwd;
            exmem_rd         <= rd_addr;
            exmem_RegWrite   <= load_valid && RegWrite;
            exmem_MemRead    <= load_valid && MemRead;
            exmem_MemWrite   <= load_valid && MemWrite;
            exmem_MemToReg   <= load_valid && MemToReg;
            exmem_zero       <= load_valid && alu_zero;
            ex_illegal_op    <= idex_valid && is_null;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage. Each cycle's stimulus produces an
// expected EX/MEM image that is queued, then popped and compared after the
// clock edge. Compile with +define+EX_FWD_EN to exercise forwarding.
// ----------------------------------------------------------------------------
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic        stall;
        logic        flush;
        logic [4:0]  op;
        logic        alusrc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic [4:0]  memRd;
        logic [4:0]  wbRd;
        logic        memRw;
        logic        wbRw;
        logic [31:0] memFwd;
        logic [31:0] wbFwd;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        zero;
        logic        ill;
        logic        chkData;
    } want_t;

    logic        clk;
    logic        rst_n;
    logic        idex_valid, ex_stall, ex_flush;
    logic [4:0]  ALUControl;
    logic        ALUSrc;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        RegWrite, MemRead, MemWrite, MemToReg;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        exmem_valid;
    logic [31:0] exmem_alu_result, exmem_store_data;
    logic [4:0]  exmem_rd;
    logic        exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg;
    logic        exmem_zero;
    logic        ex_illegal_op;

    int    checks   = 0;
    int    failures = 0;
    want_t model    = '{default: '0};
    want_t sbQ[$];

    ex_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .idex_valid       (idex_valid),
        .ex_stall         (ex_stall),
        .ex_flush         (ex_flush),
        .ALUControl       (ALUControl),
        .ALUSrc           (ALUSrc),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .imm              (imm),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rd_addr          (rd_addr),
        .RegWrite         (RegWrite),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .MemToReg         (MemToReg),
        .mem_rd           (mem_rd),
        .wb_rd            (wb_rd),
        .mem_regwrite     (mem_regwrite),
        .wb_regwrite      (wb_regwrite),
        .mem_fwd_data     (mem_fwd_data),
        .wb_fwd_data      (wb_fwd_data),
        .exmem_valid      (exmem_valid),
        .exmem_alu_result (exmem_alu_result),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd),
        .exmem_RegWrite   (exmem_RegWrite),
        .exmem_MemRead    (exmem_MemRead),
        .exmem_MemWrite   (exmem_MemWrite),
        .exmem_MemToReg   (exmem_MemToReg),
        .exmem_zero       (exmem_zero),
        .ex_illegal_op    (ex_illegal_op)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference ALU written straight from the operation definitions
    function automatic logic [31:0] aluRef(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OPADD:   return a + b;
            OPSUB:   return a - b;
            OPAND:   return a & b;
            OPOR:    return a | b;
            OPSLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Operand value seen by EX for one source register
    function automatic logic [31:0] srcRef(input stim_t s, input logic [4:0] addr, input logic [31:0] rf);
`ifdef EX_FWD_EN
        if (s.memRw && s.memRd == addr && addr != 5'd0) return s.memFwd;
        if (s.wbRw && s.wbRd == addr && addr != 5'd0) return s.wbFwd;
`endif
        return rf;
    endfunction

    function automatic stim_t baseStim();
        stim_t s = '{default: '0};
        s.rst_n = 1'b1;
        s.valid = 1'b1;
        s.rs1a  = 5'd1;
        s.rs2a  = 5'd2;
        s.rd    = 5'd5;
        s.ctrl  = 4'b1000;
        s.memRd = 5'd30;
        s.wbRd  = 5'd31;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        logic [4:0] ops [7];
        ops = '{OPADD, OPSUB, OPAND, OPOR, OPSLT, OPNULL, 5'b01010};
        s.rst_n  = 1'b1;
        s.valid  = ($urandom_range(0, 5) != 0);
        s.stall  = ($urandom_range(0, 4) == 0);
        s.flush  = ($urandom_range(0, 6) == 0);
        s.op     = ops[$urandom_range(0, 6)];
        s.alusrc = 1'($urandom_range(0, 1));
        s.rs1d   = $urandom;
        s.rs2d   = ($urandom_range(0, 3) == 0) ? s.rs1d : $urandom;
        s.imm    = $urandom;
        s.rs1a   = 5'($urandom_range(0, 3));
        s.rs2a   = 5'($urandom_range(0, 3));
        s.rd     = 5'($urandom);
        s.ctrl   = 4'($urandom);
        s.memRd  = 5'($urandom_range(0, 3));
        s.wbRd   = 5'($urandom_range(0, 3));
        s.memRw  = 1'($urandom_range(0, 1));
        s.wbRw   = 1'($urandom_range(0, 1));
        s.memFwd = $urandom;
        s.wbFwd  = $urandom;
        return s;
    endfunction

    // Drive one cycle, queue the expected EX/MEM image, then compare it after the edge
    task automatic applyStimulus(input string tag, input stim_t s);
        want_t w;
        want_t got;
        logic [31:0] a, b, r2;
        @(negedge clk);
        rst_n        = s.rst_n;
        idex_valid   = s.valid;
        ex_stall     = s.stall;
        ex_flush     = s.flush;
        ALUControl   = s.op;
        ALUSrc       = s.alusrc;
        rs1_data     = s.rs1d;
        rs2_data     = s.rs2d;
        imm          = s.imm;
        rs1_addr     = s.rs1a;
        rs2_addr     = s.rs2a;
        rd_addr      = s.rd;
        {RegWrite, MemRead, MemWrite, MemToReg} = s.ctrl;
        mem_rd       = s.memRd;
        wb_rd        = s.wbRd;
        mem_regwrite = s.memRw;
        wb_regwrite  = s.wbRw;
        mem_fwd_data = s.memFwd;
        wb_fwd_data  = s.wbFwd;

        a  = srcRef(s, s.rs1a, s.rs1d);
        r2 = srcRef(s, s.rs2a, s.rs2d);
        b  = s.alusrc ? s.imm : r2;
        if (!s.rst_n || s.flush) begin
            w = '{default: '0};
            w.chkData = 1'b1;
        end else if (s.stall) begin
            w = model;
            w.ill = 1'b0;
        end else begin
            w.valid   = s.valid && (s.op != OPNULL);
            w.result  = aluRef(s.op, a, b);
            w.store   = r2;
            w.rd      = s.rd;
            w.ctrl    = w.valid ? s.ctrl : 4'b0000;
            w.zero    = w.valid && (w.result == 32'd0);
            w.ill     = s.valid && (s.op == OPNULL);
            w.chkData = w.valid;
        end
        model = w;
        sbQ.push_back(w);

        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkOutput({tag, ".valid"}, 32'(exmem_valid), 32'(got.valid));
        checkOutput({tag, ".ctrl"}, 32'({exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg}), 32'(got.ctrl));
        checkOutput({tag, ".zero"}, 32'(exmem_zero), 32'(got.zero));
        checkOutput({tag, ".illegal"}, 32'(ex_illegal_op), 32'(got.ill));
        if (got.chkData) begin
            checkOutput({tag, ".result"}, exmem_alu_result, got.result);
            checkOutput({tag, ".store"}, exmem_store_data, got.store);
            checkOutput({tag, ".rd"}, 32'(exmem_rd), 32'(got.rd));
        end
    endtask

    initial begin
        stim_t s;

        // Reset held for three cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            s = randStim();
            s.rst_n = 1'b0;
            s.stall = 1'($urandom_range(0, 1));
            s.flush = 1'($urandom_range(0, 1));
            applyStimulus("reset", s);
        end

        s = baseStim(); s.op = OPSUB; s.rs1d = 32'd5; s.rs2d = 32'd7;
        applyStimulus("sub", s);
        s.op = OPSLT;
        applyStimulus("slt", s);
        s = baseStim(); s.op = OPADD; s.rs1d = 32'hFFFF_FFFF; s.imm = 32'd1; s.alusrc = 1'b1;
        applyStimulus("add_wrap", s);
        s = baseStim(); s.op = OPAND; s.rs1d = 32'hF0F0_1234; s.rs2d = 32'h0FF0_FF00; s.ctrl = 4'b0110;
        applyStimulus("and", s);
        s.op = OPOR;
        applyStimulus("or", s);
        s = baseStim(); s.op = OPSLT; s.rs1d = 32'h8000_0000; s.rs2d = 32'd1;
        applyStimulus("slt_neg", s);

        // Forwarding: MEM beats WB on rs1; WB-only hit on rs2; x0 never forwarded
        s = baseStim(); s.op = OPADD; s.alusrc = 1'b1; s.imm = 32'd0;
        s.rs1a = 5'd3; s.rs1d = 32'h10; s.memRd = 5'd3; s.wbRd = 5'd3;
        s.memRw = 1'b1; s.wbRw = 1'b1; s.memFwd = 32'h100; s.wbFwd = 32'h200;
        applyStimulus("fwd_mem", s);
        s.rs1a = 5'd0; s.memRd = 5'd0; s.wbRd = 5'd0;
        applyStimulus("fwd_x0", s);
        s = baseStim(); s.op = OPSUB; s.rs2a = 5'd4; s.rs2d = 32'h44; s.rs1d = 32'h1000;
        s.memRd = 5'd3; s.wbRd = 5'd4; s.memRw = 1'b1; s.wbRw = 1'b1;
        s.memFwd = 32'h111; s.wbFwd = 32'h222; s.ctrl = 4'b0010;
        applyStimulus("fwd_wb", s);

        // Stall two cycles with changing inputs, then stall+flush
        s = baseStim(); s.op = OPADD; s.rs1d = 32'd40; s.rs2d = 32'd2;
        applyStimulus("pre_stall", s);
        for (int i = 0; i < 2; i++) begin
            s = randStim(); s.stall = 1'b1; s.flush = 1'b0;
            applyStimulus("stall", s);
        end
        s = baseStim(); s.stall = 1'b1; s.flush = 1'b1; s.op = OPADD; s.rs1d = 32'd9;
        applyStimulus("stall_flush", s);

        // Squashed OPNULL, then a normal load clears the pulse
        s = baseStim(); s.op = OPNULL; s.ctrl = 4'b1111;
        applyStimulus("opnull", s);
        s = baseStim(); s.op = OPADD; s.rs1d = 32'd3; s.rs2d = 32'd4;
        applyStimulus("post_null", s);
        s = baseStim(); s.op = OPNULL; s.stall = 1'b1;
        applyStimulus("opnull_stalled", s);
        s = baseStim(); s.valid = 1'b0; s.op = OPADD; s.ctrl = 4'b1111;
        applyStimulus("bubble", s);
        s = baseStim(); s.flush = 1'b1; s.op = OPOR; s.rs1d = 32'hFF;
        applyStimulus("flush", s);

        for (int i = 0; i < 60; i++) begin
            applyStimulus("random", randStim());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
